// File: rtl/pag_refill_seq_pkg.sv
// Shared types and constants for the page-table refill sequencer and its
// address mapper.
package pag_refill_seq_pkg;

  localparam int DATA_W = 36;
  localparam int ADR_W  = 22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

  // Word offsets of the page-table halves inside a base page (octal)
  localparam logic [ADR_W-1:0] OFS_EXEC_LO = 22'o600;
  localparam logic [ADR_W-1:0] OFS_SHARED  = 22'o400;
  localparam logic [ADR_W-1:0] OFS_EXEC_HI = 22'o200;

  localparam logic [8:0] PAGE_SHARED_LO = 9'o340;
  localparam logic [8:0] PAGE_EXEC_HI   = 9'o400;

  localparam logic [7:0] WD_LIMIT = 8'd255;

endpackage

// File: rtl/pag_refill_adr.sv
// Combinational page-table word address for a VMA page: two page entries
// share one table word, so the page number is halved after rebasing.
module pag_refill_adr
  import pag_refill_seq_pkg::*;
(
  input  logic        user,
  input  logic [8:0]  page,
  input  logic [12:0] ubr,
  input  logic [12:0] ebr,
  output logic [21:0] adr
);

  logic [ADR_W-1:0] ubr_base;
  logic [ADR_W-1:0] ebr_base;
  logic [8:0]       rel;

  always_comb begin
    ubr_base = {ubr, 9'd0};
    ebr_base = {ebr, 9'd0};
    rel      = '0;
    adr      = '0;
    if (user) begin
      adr = ubr_base + 22'(page >> 1);
    end else if (page < PAGE_SHARED_LO) begin
      adr = ebr_base + OFS_EXEC_LO + 22'(page >> 1);
    end else if (page < PAGE_EXEC_HI) begin
      // Exec pages 0340-0377 live in the user page table
      rel = page - PAGE_SHARED_LO;
      adr = ubr_base + OFS_SHARED + 22'(rel >> 1);
    end else begin
      rel = page - PAGE_EXEC_HI;
      adr = ebr_base + OFS_EXEC_HI + 22'(rel >> 1);
    end
  end

endmodule

// File: rtl/pag_refill_seq.sv
// Page-table refill sequencer: fetches one page-table word from memory,
// checks parity/errors under a watchdog and writes it into the page table.
module pag_refill_seq
  import pag_refill_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        refill_req,
  input  logic        vma_user,
  input  logic [8:0]  vma_page,
  input  logic [12:0] ubr,
  input  logic [12:0] ebr,
  output logic        mem_rd_req,
  output logic [21:0] mem_adr,
  input  logic        mem_ack,
  input  logic        mem_data_valid,
  input  logic [35:0] mem_data,
  input  logic        mem_par,
  input  logic        mem_error,
  input  logic        refill_abort,
  output logic        pt_wr,
  output logic        pt_dir_wr,
  output logic [35:0] pt_wr_data,
  output logic        refill_busy,
  output logic        refill_done,
  output logic        refill_error
);

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       wd_q;
  logic [ADR_W-1:0] adr_next;
  logic             par_ok;

  pag_refill_adr u_adr (
    .user (vma_user),
    .page (vma_page),
    .ubr  (ubr),
    .ebr  (ebr),
    .adr  (adr_next)
  );

  // Odd parity across the 36 data bits plus the parity bit
  assign par_ok = ^{mem_data, mem_par};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (refill_req) state_d = ST_REQ;
      ST_REQ: begin
        if (refill_abort)  state_d = ST_IDLE;
        else if (mem_ack)  state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (refill_abort)              state_d = ST_IDLE;
        else if (mem_error)            state_d = ST_ERR;
        else if (mem_data_valid)       state_d = par_ok ? ST_WRITE : ST_ERR;
        else if (wd_q == WD_LIMIT)     state_d = ST_ERR;
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are decoded from the next state so they appear with the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q         <= '0;
      mem_adr      <= '0;
      pt_wr_data   <= '0;
      mem_rd_req   <= 1'b0;
      pt_wr        <= 1'b0;
      pt_dir_wr    <= 1'b0;
      refill_busy  <= 1'b0;
      refill_done  <= 1'b0;
      refill_error <= 1'b0;
    end else begin
      wd_q <= (state_q == ST_WAIT) ? wd_q + 8'd1 : 8'd0;
      if (state_q == ST_IDLE && refill_req) mem_adr <= adr_next;
      if (state_q == ST_WAIT && mem_data_valid) pt_wr_data <= mem_data;
      mem_rd_req   <= (state_d == ST_REQ);
      pt_wr        <= (state_d == ST_WRITE);
      pt_dir_wr    <= (state_d == ST_WRITE);
      refill_busy  <= (state_d != ST_IDLE);
      refill_done  <= (state_d == ST_DONE);
      refill_error <= (state_d == ST_ERR);
    end
  end

endmodule

// File: tb/tb_pag_refill_seq.sv
// Directed self-checking bench for pag_refill_seq.
module tb_pag_refill_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        refill_req;
  logic        vma_user;
  logic [8:0]  vma_page;
  logic [12:0] ubr;
  logic [12:0] ebr;
  logic        mem_rd_req;
  logic [21:0] mem_adr;
  logic        mem_ack;
  logic        mem_data_valid;
  logic [35:0] mem_data;
  logic        mem_par;
  logic        mem_error;
  logic        refill_abort;
  logic        pt_wr;
  logic        pt_dir_wr;
  logic [35:0] pt_wr_data;
  logic        refill_busy;
  logic        refill_done;
  logic        refill_error;

  int n_tests = 0;
  int n_fail  = 0;

  pag_refill_seq dut (
    .clk            (clk),
    .reset          (reset),
    .refill_req     (refill_req),
    .vma_user       (vma_user),
    .vma_page       (vma_page),
    .ubr            (ubr),
    .ebr            (ebr),
    .mem_rd_req     (mem_rd_req),
    .mem_adr        (mem_adr),
    .mem_ack        (mem_ack),
    .mem_data_valid (mem_data_valid),
    .mem_data       (mem_data),
    .mem_par        (mem_par),
    .mem_error      (mem_error),
    .refill_abort   (refill_abort),
    .pt_wr          (pt_wr),
    .pt_dir_wr      (pt_dir_wr),
    .pt_wr_data     (pt_wr_data),
    .refill_busy    (refill_busy),
    .refill_done    (refill_done),
    .refill_error   (refill_error)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 'o%0o expected 'o%0o", tag, obs, exp);
    end
  endtask

  function automatic logic good_par(input logic [35:0] d);
    return ~(^d);
  endfunction

  // Launch a request, ack it at once and leave the DUT in WAIT
  task automatic to_wait(input logic u, input logic [8:0] p, input logic [12:0] ub,
                         input logic [12:0] eb);
    refill_req = 1'b1; vma_user = u; vma_page = p; ubr = ub; ebr = eb;
    tick;
    refill_req = 1'b0; mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
  endtask

  // Launch a request, check its address, then abort from REQ
  task automatic map_chk(input string tag, input logic [8:0] p, input logic [12:0] ub,
                         input logic [12:0] eb, input logic [21:0] exp_adr);
    refill_req = 1'b1; vma_user = 1'b0; vma_page = p; ubr = ub; ebr = eb;
    tick;
    refill_req = 1'b0;
    chk(tag, 64'(mem_adr), 64'(exp_adr));
    refill_abort = 1'b1;
    tick;
    refill_abort = 1'b0;
    chk({tag, "_abort_idle"}, 64'({refill_busy, mem_rd_req, refill_done, refill_error}), 64'd0);
  endtask

  logic [35:0] d0;
  logic [35:0] d1;
  int          n;
  int          wr_cnt;

  initial begin
    reset = 1'b1; refill_req = 1'b0; vma_user = 1'b0; vma_page = '0; ubr = '0; ebr = '0;
    mem_ack = 1'b0; mem_data_valid = 1'b0; mem_data = '0; mem_par = 1'b0;
    mem_error = 1'b0; refill_abort = 1'b0;
    d0 = 36'o400123400456;
    d1 = 36'o123456701234;

    tick; tick;
    chk("reset_ctl", 64'({mem_rd_req, pt_wr, pt_dir_wr, refill_busy, refill_done, refill_error}), 64'd0);
    chk("reset_adr", 64'(mem_adr), 64'd0);
    chk("reset_data", 64'(pt_wr_data), 64'd0);
    reset = 1'b0;
    tick;

    // Basic user refill with minimum latency
    refill_req = 1'b1; vma_user = 1'b1; vma_page = 9'o005; ubr = 13'o1; ebr = 13'o0;
    tick;
    refill_req = 1'b0;
    chk("basic_rd_req", 64'(mem_rd_req), 64'd1);
    chk("basic_adr", 64'(mem_adr), 64'o1002);
    chk("basic_busy", 64'(refill_busy), 64'd1);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("basic_wait", 64'({mem_rd_req, pt_wr}), 64'd0);
    mem_data_valid = 1'b1; mem_data = d0; mem_par = good_par(d0);
    tick;
    mem_data_valid = 1'b0;
    chk("basic_pt_wr_c3", 64'({pt_wr, pt_dir_wr, refill_done}), 64'b110);
    chk("basic_data", 64'(pt_wr_data), 64'(d0));
    tick;
    chk("basic_done_c4", 64'({pt_wr, pt_dir_wr, refill_done, refill_error}), 64'b0010);
    tick;
    chk("basic_idle", 64'({refill_busy, refill_done}), 64'd0);

    // Exec address mapping across every region
    map_chk("map_0341", 9'o341, 13'o3, 13'o2, 22'o3400);
    map_chk("map_0377", 9'o377, 13'o3, 13'o2, 22'o3417);
    map_chk("map_0777", 9'o777, 13'o3, 13'o2, 22'o2377);
    map_chk("map_0000_e2", 9'o000, 13'o3, 13'o2, 22'o2600);
    map_chk("map_0000_e1", 9'o000, 13'o3, 13'o1, 22'o1600);
    map_chk("map_0337", 9'o337, 13'o3, 13'o2, 22'o2757);
    map_chk("map_0400", 9'o400, 13'o3, 13'o2, 22'o2200);

    // Bad parity
    to_wait(1'b1, 9'o010, 13'o1, 13'o2);
    mem_data_valid = 1'b1; mem_data = d1; mem_par = ~good_par(d1);
    tick;
    mem_data_valid = 1'b0;
    chk("par_err", 64'({pt_wr, pt_dir_wr, refill_done, refill_error}), 64'b0001);
    tick;
    chk("par_idle", 64'({refill_busy, refill_error, pt_wr}), 64'd0);

    // mem_error beats simultaneous good data
    to_wait(1'b1, 9'o010, 13'o1, 13'o2);
    mem_data_valid = 1'b1; mem_error = 1'b1; mem_data = d1; mem_par = good_par(d1);
    tick;
    mem_data_valid = 1'b0; mem_error = 1'b0;
    chk("memerr_err", 64'({pt_wr, pt_dir_wr, refill_done, refill_error}), 64'b0001);
    tick;
    chk("memerr_idle", 64'({refill_busy, refill_error}), 64'd0);

    // Watchdog timeout
    to_wait(1'b1, 9'o010, 13'o1, 13'o2);
    n = 0; wr_cnt = 0;
    for (int i = 0; i < 300 && !refill_error; i++) begin
      tick;
      n++;
      if (pt_wr) wr_cnt++;
    end
    chk("wd_cycles", 64'(n), 64'd256);
    chk("wd_error", 64'({refill_error, refill_done, wr_cnt != 0}), 64'b100);

    // Abort in WAIT, late data ignored
    tick;
    to_wait(1'b1, 9'o010, 13'o1, 13'o2);
    refill_abort = 1'b1;
    tick;
    refill_abort = 1'b0;
    chk("abort_wait", 64'({refill_busy, pt_wr, refill_done, refill_error}), 64'd0);
    mem_data_valid = 1'b1; mem_data = d1; mem_par = good_par(d1);
    tick;
    mem_data_valid = 1'b0;
    chk("abort_late_data", 64'({refill_busy, pt_wr, refill_done, refill_error}), 64'd0);

    // Abort during WRITE is ignored
    to_wait(1'b1, 9'o010, 13'o1, 13'o2);
    mem_data_valid = 1'b1; mem_data = d1; mem_par = good_par(d1);
    tick;
    mem_data_valid = 1'b0;
    chk("abort_wr_pt_wr", 64'(pt_wr), 64'd1);
    refill_abort = 1'b1;
    tick;
    refill_abort = 1'b0;
    chk("abort_wr_done", 64'(refill_done), 64'd1);
    tick;

    // refill_req held through a whole refill yields a single refill
    wr_cnt = 0;
    refill_req = 1'b1; vma_user = 1'b1; vma_page = 9'o002; ubr = 13'o4;
    tick;
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0; mem_data_valid = 1'b1; mem_data = d0; mem_par = good_par(d0);
    tick;
    mem_data_valid = 1'b0;
    if (pt_wr) wr_cnt++;
    tick;
    chk("held_done", 64'(refill_done), 64'd1);
    tick;
    refill_req = 1'b0;
    chk("held_idle", 64'(refill_busy), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick;
      if (pt_wr || refill_busy) wr_cnt++;
    end
    chk("held_one_refill", 64'(wr_cnt), 64'd1);

    // Reset in WAIT, then a clean refill; REQ ignores error/data strobes
    to_wait(1'b1, 9'o010, 13'o1, 13'o2);
    reset = 1'b1;
    #1;
    chk("rst_wait_ctl", 64'({mem_rd_req, pt_wr, pt_dir_wr, refill_busy, refill_done, refill_error}), 64'd0);
    chk("rst_wait_dat", 64'({mem_adr, pt_wr_data}), 64'd0);
    tick;
    reset = 1'b0;
    tick;
    refill_req = 1'b1; vma_user = 1'b1; vma_page = 9'o777; ubr = 13'o7;
    tick;
    refill_req = 1'b0;
    chk("post_rst_adr", 64'(mem_adr), 64'o7377);
    mem_error = 1'b1; mem_data_valid = 1'b1;
    tick;
    mem_error = 1'b0; mem_data_valid = 1'b0;
    chk("req_ignores_err", 64'({mem_rd_req, refill_error, refill_busy}), 64'b101);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0; mem_data_valid = 1'b1; mem_data = d1; mem_par = good_par(d1);
    tick;
    mem_data_valid = 1'b0;
    chk("post_rst_wr", 64'({pt_wr, pt_dir_wr}), 64'b11);
    chk("post_rst_data", 64'(pt_wr_data), 64'(d1));
    tick;
    chk("post_rst_done", 64'({refill_done, refill_error}), 64'b10);
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
